avg_symbol_slicer: RTL and testbench

//  Downstream stage of the moving-average FIR. Consumes each 24-bit signed filtered

---
 rtl/avg_symbol_slicer.sv | 209 ++++++++++++++++++++
 tb/tb_avg_symbol_slicer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avg_symbol_slicer.sv
// avg_symbol_slicer
//   Hysteresis slicer with symbol-timing recovery for the moving-average FIR
//   output. Each filtered sample updates a hysteresis level; the first level
//   transition after the settle window sets the symbol phase, and one hard bit
//   per symbol (the mid-symbol level) is queued in a 4-entry bit FIFO with a
//   valid/ready handshake.
//   Optional feature: define SLICER_REALIGN_EN to re-sync the symbol phase on
//   every level transition while tracking. Without it, the phase counter
//   free-runs after acquisition.
module avg_symbol_slicer #(
    parameter int                      WIDTH   = 24,
    parameter int                      SPS     = 16,
    parameter logic signed [WIDTH-1:0] THRESH  = '0,
    parameter logic        [WIDTH-2:0] HYST    = (WIDTH-1)'(4096),
    parameter int                      SETTLE  = 1024,
    parameter int                      MAX_RUN = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    SAMPLE_EN,
    input  logic signed [WIDTH-1:0] DIN,
    output logic                    BIT_OUT,
    output logic                    BIT_VALID,
    input  logic                    BIT_READY,
    output logic                    LOCKED,
    output logic                    OVERFLOW
);

    localparam int CW = (SPS > 2) ? $clog2(SPS) : 1;
    localparam int RW = $clog2(MAX_RUN + 1);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CW-1:0] PHASE_MID  = CW'(SPS / 2 - 1);
    localparam logic [CW-1:0] PHASE_LAST = CW'(SPS - 1);
    localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE - 1);
    localparam logic [RW-1:0] RUN_LIMIT  = RW'(MAX_RUN);

    // Band edges carried one bit wider than the samples so THRESH +/- HYST
    // can never wrap around.
    localparam logic signed [WIDTH:0] UPPER =
        $signed({THRESH[WIDTH-1], THRESH}) + $signed({2'b00, HYST});
    localparam logic signed [WIDTH:0] LOWER =
        $signed({THRESH[WIDTH-1], THRESH}) - $signed({2'b00, HYST});

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_SEARCH,
        ST_TRACK
    } state_t;

    state_t state, state_nx;

    logic                   level, level_nx;
    logic                   trans;
    logic signed [WIDTH:0]  din_ext;

    logic [SW-1:0]          settle_cnt;
    logic [CW-1:0]          phase, phase_nx;
    logic                   phase_wrap;
    logic [RW-1:0]          run, run_nx;
    logic                   run_hit;

    logic                   locked;
    logic                   push;

    logic [3:0]             fifo_mem;
    logic [1:0]             rd_ptr, wr_ptr;
    logic [2:0]             count;
    logic                   fifo_full, fifo_empty;
    logic                   do_pop, do_push, drop;
    logic                   ovf;

    assign din_ext = {DIN[WIDTH-1], DIN};

    // Hysteresis decision: outside the band forces the level, inside holds it
    always_comb begin
        level_nx = level;
        if (din_ext > UPPER) begin
            level_nx = 1'b1;
        end else if (din_ext < LOWER) begin
            level_nx = 1'b0;
        end
    end

    assign trans = SAMPLE_EN & (level_nx ^ level);

    // Level register, advanced only by new samples
    always_ff @(posedge CLK) begin
        if (RST) begin
            level <= 1'b0;
        end else if (SAMPLE_EN) begin
            level <= level_nx;
        end
    end

    // Phase and run-length bookkeeping for the tracking state
    always_comb begin
        phase_wrap = (phase == PHASE_LAST);
        phase_nx   = phase_wrap ? '0 : phase + 1'b1;
`ifdef SLICER_REALIGN_EN
        if (trans) begin
            phase_nx = '0;
        end
`endif
        run_nx = run;
        if (trans) begin
            run_nx = '0;
        end else if (phase_wrap) begin
            run_nx = run + 1'b1;
        end
        run_hit = (run_nx == RUN_LIMIT);
    end

    // Settle, phase and run counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            settle_cnt <= '0;
            phase      <= '0;
            run        <= '0;
        end else if (SAMPLE_EN) begin
            case (state)
                ST_SETTLE: settle_cnt <= settle_cnt + 1'b1;
                ST_SEARCH: begin
                    if (trans) begin
                        phase <= '0;
                        run   <= '0;
                    end
                end
                ST_TRACK: begin
                    phase <= phase_nx;
                    run   <= run_nx;
                end
                default: ;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_SETTLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic; every transition waits for a sample strobe
    always_comb begin
        state_nx = state;
        if (SAMPLE_EN) begin
            case (state)
                ST_SETTLE: if (settle_cnt == SETTLE_END) state_nx = ST_SEARCH;
                ST_SEARCH: if (trans)                    state_nx = ST_TRACK;
                ST_TRACK:  if (run_hit)                  state_nx = ST_SEARCH;
                default:                                 state_nx = ST_SETTLE;
            endcase
        end
    end

    // FSM outputs: lock flag and the mid-symbol decision strobe
    always_comb begin
        locked = 1'b0;
        push   = 1'b0;
        if (state == ST_TRACK) begin
            locked = 1'b1;
            push   = SAMPLE_EN && (phase == PHASE_MID);
        end
    end

    assign fifo_empty = (count == 3'd0);
    assign fifo_full  = (count == 3'd4);
    assign do_pop     = !fifo_empty && BIT_READY;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_push    = push && (!fifo_full || do_pop);
    assign drop       = push && fifo_full && !do_pop;

    // Decision FIFO and sticky overflow flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            fifo_mem <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
        end else begin
            if (do_push) begin
                fifo_mem[wr_ptr] <= level_nx;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    assign BIT_VALID = !fifo_empty;
    assign BIT_OUT   = !fifo_empty & fifo_mem[rd_ptr];
    assign LOCKED    = locked;
    assign OVERFLOW  = ovf;

endmodule

// File: tb/tb_avg_symbol_slicer.sv
// tb_avg_symbol_slicer
//   Randomized scenarios for avg_symbol_slicer (SETTLE=8, SPS=16, MAX_RUN=64),
//   checked against a sample-level behavioural model and against explicit
//   expectations for latency, ordering, overflow and lock behaviour.
module tb_avg_symbol_slicer;

    localparam int W       = 24;
    localparam int SPS     = 16;
    localparam int SETTLE  = 8;
    localparam int MAX_RUN = 64;
    localparam int THRESH  = 0;
    localparam int HYST    = 4096;

    localparam int M_SETTLE = 0;
    localparam int M_SEARCH = 1;
    localparam int M_TRACK  = 2;

    logic                CLK = 1'b0;
    logic                RST;
    logic                SAMPLE_EN;
    logic signed [W-1:0] DIN;
    logic                BIT_OUT;
    logic                BIT_VALID;
    logic                BIT_READY;
    logic                LOCKED;
    logic                OVERFLOW;

    int checks = 0;
    int passed = 0;

    // Model state: level, mode, samples since lock edge, symbols without edge
    bit m_l;
    int m_mode;
    int m_nsamp;
    int m_k;
    int m_run;
    bit m_q[$];
    bit m_ovf;
    bit m_decide;

    // Bits actually accepted from the DUT by the consumer
    bit got[$];

    avg_symbol_slicer #(
        .WIDTH   (W),
        .SPS     (SPS),
        .SETTLE  (SETTLE),
        .MAX_RUN (MAX_RUN)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .SAMPLE_EN (SAMPLE_EN),
        .DIN       (DIN),
        .BIT_OUT   (BIT_OUT),
        .BIT_VALID (BIT_VALID),
        .BIT_READY (BIT_READY),
        .LOCKED    (LOCKED),
        .OVERFLOW  (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    function automatic int big(input bit pos);
        int a;
        a = 1000000 + int'($urandom_range(0, 50000));
        return pos ? a : -a;
    endfunction

    function automatic logic [3:0] m_exp();
        logic v;
        logic h;
        v = (m_q.size() > 0);
        h = v ? m_q[0] : 1'b0;
        return {v, h, (m_mode == M_TRACK), m_ovf};
    endfunction

    task automatic model_reset();
        m_l = 1'b0; m_mode = M_SETTLE; m_nsamp = 0; m_k = 0; m_run = 0;
        m_q.delete(); m_ovf = 1'b0; m_decide = 1'b0;
    endtask

    task automatic model_sample(input int d);
        bit nl;
        bit t;
        nl = (d > THRESH + HYST) ? 1'b1 : (d < THRESH - HYST) ? 1'b0 : m_l;
        t = (nl != m_l);
        m_l = nl;
        m_decide = 1'b0;
        case (m_mode)
            M_SETTLE: begin
                m_nsamp++;
                if (m_nsamp == SETTLE) m_mode = M_SEARCH;
            end
            M_SEARCH: begin
                if (t) begin m_mode = M_TRACK; m_k = 0; m_run = 0; end
            end
            default: begin
                m_k++;
                m_decide = (m_k % SPS == SPS / 2);
                if (t) m_run = 0;
                else if (m_k % SPS == 0) m_run++;
`ifdef SLICER_REALIGN_EN
                if (t) m_k = 0;
`endif
                if (m_run == MAX_RUN) m_mode = M_SEARCH;
            end
        endcase
    endtask

    // One clock: drive inputs, record accepted bit, advance model, sample at +1
    task automatic tick(input bit en, input int d, input bit rdy);
        bit pop;
        SAMPLE_EN = en; DIN = W'(d); BIT_READY = rdy;
        #4;
        if (BIT_VALID && BIT_READY) got.push_back(BIT_OUT);
        pop = rdy && (m_q.size() > 0);
        @(posedge CLK);
        m_decide = 1'b0;
        if (en) model_sample(d);
        if (pop) void'(m_q.pop_front());
        if (m_decide) begin
            if (m_q.size() < 4) m_q.push_back(m_l);
            else m_ovf = 1'b1;
        end
        #1;
    endtask

    // A sample preceded by a random number of idle cycles
    task automatic feed(input int d, input bit rdy);
        repeat ($urandom_range(0, 1)) tick(1'b0, int'($urandom), rdy);
        tick(1'b1, d, rdy);
    endtask

    task automatic do_reset();
        RST = 1'b1; SAMPLE_EN = 1'b1; DIN = W'(big(1)); BIT_READY = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        #1;
        RST = 1'b0; SAMPLE_EN = 1'b0;
        model_reset();
        got.delete();
    endtask

    // Settle window filled with a strong low level (no transitions)
    task automatic settle_low(input bit rdy);
        for (int i = 0; i < SETTLE; i++) feed(big(0), rdy);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({BIT_VALID, BIT_OUT, LOCKED, OVERFLOW} !== 4'b0000)
            $display("FAIL reset_state: {valid,bit,locked,ovf} got %b expected 0000",
                     {BIT_VALID, BIT_OUT, LOCKED, OVERFLOW});
        else passed++;
    endtask

    task automatic test_settle_lock();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            feed((i < 7) ? big(1) : big(0), 1'b1);
            checks++;
            if ({BIT_VALID, BIT_OUT, LOCKED, OVERFLOW} !== m_exp())
                $display("FAIL settle_model: got %b expected %b",
                         {BIT_VALID, BIT_OUT, LOCKED, OVERFLOW}, m_exp());
            else passed++;
        end
        checks++;
        if (LOCKED !== 1'b0) $display("FAIL settle_nolock: LOCKED got %b expected 0", LOCKED);
        else passed++;
        feed(big(1), 1'b1);
        checks++;
        if (LOCKED !== 1'b1) $display("FAIL settle_lock: LOCKED got %b expected 1", LOCKED);
        else passed++;
    endtask

    task automatic test_square();
        int j;
        do_reset();
        settle_low(1'b1);
        j = 0;
        for (int p = 0; p < 5; p++) begin
            for (int s = 0; s < 32; s++) begin
                feed(big(s < 16), 1'b1);
                checks++;
                if ({BIT_VALID, BIT_OUT, LOCKED, OVERFLOW} !== m_exp())
                    $display("FAIL square_model: got %b expected %b",
                             {BIT_VALID, BIT_OUT, LOCKED, OVERFLOW}, m_exp());
                else passed++;
                if (j >= 1 && j <= 8) begin
                    checks++;
                    if (BIT_VALID !== (j == 8))
                        $display("FAIL square_latency: sample %0d BIT_VALID got %b expected %b",
                                 j, BIT_VALID, (j == 8));
                    else passed++;
                end
                j++;
            end
        end
        repeat (2) tick(1'b0, 0, 1'b1);
        checks++;
        if (got.size() != 10) $display("FAIL square_count: bits got %0d expected 10", got.size());
        else passed++;
        for (int i = 0; i < got.size() && i < 10; i++) begin
            checks++;
            if (got[i] !== ((i % 2) == 0))
                $display("FAIL square_bits: bit %0d got %b expected %b", i, got[i], ((i % 2) == 0));
            else passed++;
        end
    endtask

    task automatic test_deadband();
        do_reset();
        for (int i = 0; i < SETTLE + 200; i++) begin
            int a;
            a = int'($urandom_range(0, 4096));
            feed((i % 2) ? a : -a, 1'b1);
            checks++;
            if ({BIT_VALID, BIT_OUT, LOCKED, OVERFLOW} !== m_exp())
                $display("FAIL deadband_model: got %b expected %b",
                         {BIT_VALID, BIT_OUT, LOCKED, OVERFLOW}, m_exp());
            else passed++;
        end
        feed(4096, 1'b1);
        checks++;
        if ({LOCKED, BIT_VALID} !== 2'b00)
            $display("FAIL deadband_edge: {locked,valid} got %b expected 00", {LOCKED, BIT_VALID});
        else passed++;
        feed(4097, 1'b1);
        checks++;
        if (LOCKED !== 1'b1) $display("FAIL deadband_cross: LOCKED got %b expected 1", LOCKED);
        else passed++;
        for (int k = 1; k <= 8; k++) feed(-4096, 1'b1);
        checks++;
        if ({BIT_VALID, BIT_OUT} !== 2'b11)
            $display("FAIL deadband_hold: {valid,bit} got %b expected 11", {BIT_VALID, BIT_OUT});
        else passed++;
    endtask

    task automatic test_overflow(input bit pop_on_fifth);
        bit sym[5];
        int n;
        do_reset();
        settle_low(1'b0);
        sym[0] = 1'b1;
        for (int i = 1; i < 5; i++) sym[i] = 1'($urandom);
        for (int i = 0; i < 5; i++) begin
            for (int s = 0; s <= 8 || (i < 4 && s < 16); s++) begin
                if (pop_on_fifth && i == 4 && s == 8) tick(1'b1, big(sym[i]), 1'b1);
                else feed(big(sym[i]), 1'b0);
                checks++;
                if ({BIT_VALID, BIT_OUT, LOCKED, OVERFLOW} !== m_exp())
                    $display("FAIL overflow_model: got %b expected %b",
                             {BIT_VALID, BIT_OUT, LOCKED, OVERFLOW}, m_exp());
                else passed++;
            end
        end
        checks++;
        if (OVERFLOW !== !pop_on_fifth)
            $display("FAIL overflow_flag: OVERFLOW got %b expected %b", OVERFLOW, !pop_on_fifth);
        else passed++;
        repeat (6) tick(1'b0, int'($urandom), 1'b1);
        n = pop_on_fifth ? 5 : 4;
        checks++;
        if (got.size() != n) $display("FAIL overflow_count: bits got %0d expected %0d", got.size(), n);
        else passed++;
        for (int i = 0; i < n && i < got.size(); i++) begin
            checks++;
            if (got[i] !== sym[i])
                $display("FAIL overflow_order: bit %0d got %b expected %b", i, got[i], sym[i]);
            else passed++;
        end
        checks++;
        if ({BIT_VALID, OVERFLOW} !== {1'b0, !pop_on_fifth})
            $display("FAIL overflow_drained: {valid,ovf} got %b expected %b",
                     {BIT_VALID, OVERFLOW}, {1'b0, !pop_on_fifth});
        else passed++;
    endtask

    task automatic test_run_loss();
        do_reset();
        settle_low(1'b1);
        feed(big(1), 1'b1);
        for (int k = 1; k <= MAX_RUN * SPS; k++) begin
            feed(big(1), 1'b1);
            if (k >= MAX_RUN * SPS - 1) begin
                checks++;
                if (LOCKED !== (k < MAX_RUN * SPS))
                    $display("FAIL run_lock: sample %0d LOCKED got %b expected %b",
                             k, LOCKED, (k < MAX_RUN * SPS));
                else passed++;
            end
        end
        repeat (2) tick(1'b0, 0, 1'b1);
        checks++;
        if (got.size() != MAX_RUN || got.sum() with (int'(item)) != MAX_RUN)
            $display("FAIL run_bits: ones got %0d of %0d expected %0d",
                     got.sum() with (int'(item)), got.size(), MAX_RUN);
        else passed++;
        for (int k = 0; k < 40; k++) feed(big(1), 1'b1);
        repeat (2) tick(1'b0, 0, 1'b1);
        checks++;
        if ({got.size() == MAX_RUN, LOCKED} !== 2'b10)
            $display("FAIL run_after: bits got %0d locked %b expected %0d and 0",
                     got.size(), LOCKED, MAX_RUN);
        else passed++;
    endtask

    task automatic test_realign();
        int first;
        int want;
        bit fbit;
        do_reset();
        settle_low(1'b1);
        feed(big(1), 1'b1);
        first = -1;
        fbit  = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            feed(big(k < 19), 1'b1);
            checks++;
            if ({BIT_VALID, BIT_OUT, LOCKED, OVERFLOW} !== m_exp())
                $display("FAIL realign_model: got %b expected %b",
                         {BIT_VALID, BIT_OUT, LOCKED, OVERFLOW}, m_exp());
            else passed++;
            if (k >= 19 && first < 0 && BIT_VALID) begin first = k; fbit = BIT_OUT; end
        end
`ifdef SLICER_REALIGN_EN
        want = 27;
`else
        want = 24;
`endif
        checks++;
        if (first != want)
            $display("FAIL realign_phase: decision at sample %0d expected %0d", first, want);
        else passed++;
        checks++;
        if (fbit !== 1'b0) $display("FAIL realign_bit: got %b expected 0", fbit);
        else passed++;
    endtask

    task automatic test_midop_reset();
        do_reset();
        settle_low(1'b0);
        for (int k = 0; k < 30; k++) feed(big(1), 1'b0);
        do_reset();
        checks++;
        if ({BIT_VALID, BIT_OUT, LOCKED, OVERFLOW} !== 4'b0000)
            $display("FAIL midreset_state: got %b expected 0000",
                     {BIT_VALID, BIT_OUT, LOCKED, OVERFLOW});
        else passed++;
        for (int k = 0; k < SETTLE; k++) feed((k < 7) ? big(1) : big(0), 1'b1);
        checks++;
        if (LOCKED !== 1'b0) $display("FAIL midreset_settle: LOCKED got %b expected 0", LOCKED);
        else passed++;
    endtask

    initial begin
        RST = 1'b1; SAMPLE_EN = 1'b0; DIN = '0; BIT_READY = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
        test_reset();
        test_settle_lock();
        test_square();
        test_deadband();
        test_overflow(1'b0);
        test_overflow(1'b1);
        test_run_loss();
        test_realign();
        test_midop_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
